// File: rtl/mod100_down_counter_pkg.sv
// Shared types and helpers for the modulo-MOD BCD down counter and its
// verification environment.
package mod100_down_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int MOD_MIN = 2;
  localparam int MOD_MAX = 100;

  // Binary value below 100 to packed {tens, ones} BCD pair.
  function automatic logic [7:0] bin2bcd(input int unsigned v);
    logic [7:0] r;
    r[7:4] = 4'(v / 32'd10);
    r[3:0] = 4'(v % 32'd10);
    return r;
  endfunction

  function automatic bit mod_ok(input int m, input int w);
    return (m >= MOD_MIN) && (m <= MOD_MAX) && ((32'sd1 <<< w) >= m);
  endfunction

endpackage

// File: rtl/mod100_down_counter_bcd_digit_down.sv
// Single decade down-counter digit: 0 wraps to 9 and raises a combinational
// borrow so digits can be chained within one clock.
module bcd_digit_down (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dec_in,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       borrow_out
);

  logic [3:0] digit_r;

  assign borrow_out = dec_in && (digit_r == 4'd0);
  assign digit      = digit_r;

  // Digit register: load overrides decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_r <= 4'd0;
    end else if (load) begin
      digit_r <= load_val;
    end else if (dec_in) begin
      digit_r <= (digit_r == 4'd0) ? 4'd9 : (digit_r - 4'd1);
    end else begin
      digit_r <= digit_r;
    end
  end

endmodule

// File: rtl/mod100_down_counter.sv
// Loadable modulo-MOD down counter with start/stop/pause control, one-shot
// option, terminal-count pulse and lockstep two-digit BCD outputs.
module mod100_down_counter
  import mod100_down_counter_pkg::*;
#(
  parameter int MOD      = 100,
  parameter int WIDTH    = 7,
  parameter int ONE_SHOT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             running,
  output logic             tc,
  output logic             load_err
);

  if (!mod_ok(MOD, WIDTH)) begin : g_param_err
    $error("mod100_down_counter: MOD must be 2..100 and fit in WIDTH bits");
  end

  localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
  localparam logic [7:0]       TOP_BCD = bin2bcd(MOD - 1);
  localparam bit               IS_ONE_SHOT = (ONE_SHOT != 0);

  state_e           state_r, state_s;
  logic [WIDTH-1:0] count_r, count_s;
  logic             tc_r, tc_s;
  logic             load_err_r, load_err_s;
  logic             running_r;

  logic             tick_s;
  logic             dec_s;
  logic             wrap_s;
  logic             dig_load_s;
  logic [7:0]       dig_val_s;
  logic             ones_borrow_s;
  logic             tens_borrow_s;

  assign tick_s = (state_r == ST_RUN) && en && !load && !stop;
  // A one-shot run never decrements past zero, so the digit chain is frozen there.
  assign dec_s  = tick_s && (!IS_ONE_SHOT || (count_r != ZERO_W));
  // Borrow out of the tens digit means the BCD pair read 00: time to wrap.
  assign wrap_s = !IS_ONE_SHOT && tens_borrow_s;

  // Next-state / next-count decision, priority load > stop > start > tick.
  always_comb begin
    state_s    = state_r;
    count_s    = count_r;
    tc_s       = 1'b0;
    load_err_s = 1'b0;
    dig_load_s = 1'b0;
    dig_val_s  = 8'd0;
    if (load) begin
      state_s    = ST_IDLE;
      dig_load_s = 1'b1;
      if (int'(load_val) < MOD) begin
        count_s   = load_val;
        dig_val_s = bin2bcd(int'(load_val));
      end else begin
        count_s    = TOP_VAL;
        dig_val_s  = TOP_BCD;
        load_err_s = 1'b1;
      end
    end else if (stop) begin
      if (state_r == ST_RUN) begin
        state_s = ST_PAUSE;
      end else begin
        state_s = state_r;
      end
    end else if (tick_s) begin
      if (wrap_s) begin
        count_s    = TOP_VAL;
        dig_load_s = 1'b1;
        dig_val_s  = TOP_BCD;
        tc_s       = 1'b1;
      end else if (count_r != ZERO_W) begin
        count_s = count_r - ONE_W;
        if (IS_ONE_SHOT && (count_r == ONE_W)) begin
          tc_s    = 1'b1;
          state_s = ST_DONE;
        end else begin
          tc_s = 1'b0;
        end
      end else begin
        state_s = ST_DONE;
      end
    end else if (start) begin
      case (state_r)
        ST_IDLE, ST_PAUSE: begin
          if (IS_ONE_SHOT && (count_r == ZERO_W)) begin
            state_s = state_r;
          end else begin
            state_s = ST_RUN;
          end
        end
        default: state_s = state_r;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Registered state, count and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      count_r    <= ZERO_W;
      tc_r       <= 1'b0;
      load_err_r <= 1'b0;
      running_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      tc_r       <= tc_s;
      load_err_r <= load_err_s;
      running_r  <= (state_s == ST_RUN);
    end
  end

  bcd_digit_down u_ones (
    .clk        (clk),
    .rst_n      (rst_n),
    .dec_in     (dec_s),
    .load       (dig_load_s),
    .load_val   (dig_val_s[3:0]),
    .digit      (ones),
    .borrow_out (ones_borrow_s)
  );

  bcd_digit_down u_tens (
    .clk        (clk),
    .rst_n      (rst_n),
    .dec_in     (ones_borrow_s),
    .load       (dig_load_s),
    .load_val   (dig_val_s[7:4]),
    .digit      (tens),
    .borrow_out (tens_borrow_s)
  );

  assign count    = count_r;
  assign running  = running_r;
  assign tc       = tc_r;
  assign load_err = load_err_r;

endmodule

// File: doc/mod100_down_counter.md
Name: mod100_down_counter

Overview:
- Loadable modulo-MOD down counter with two-digit BCD outputs.
- Counterpart to the team's mod-100 up counter: counts MOD-1 down to 0 and wraps to MOD-1.
- Has start/stop/load control, a tick enable for prescaled operation, an optional one-shot mode for countdown timing, and a terminal-count pulse.
- Sits beside the up counter in the timer/display path and drives seven-segment digit logic directly.

Parameters:
- MOD, 100, count modulus; legal range 2..100.
- WIDTH, 7, binary count width; must satisfy 2**WIDTH >= MOD.
- ONE_SHOT, 0, 0 = free-run wrap 0 -> MOD-1; 1 = stop at 0 and enter DONE.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  tick enable; a decrement happens only in RUN with en=1.
- load  in  1  single-cycle load strobe.
- load_val  in  WIDTH  value captured on load.
- start  in  1  single-cycle start/resume strobe.
- stop  in  1  single-cycle pause strobe.
- count  out  WIDTH  registered binary count.
- tens  out  4  registered BCD tens digit of count.
- ones  out  4  registered BCD ones digit of count.
- running  out  1  high while state is RUN.
- tc  out  1  one-cycle terminal-count pulse.
- load_err  out  1  one-cycle pulse when load_val >= MOD.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - count=0, tens=0, ones=0; state IDLE.
  - running=0, tc=0, load_err=0.
  - Takes effect immediately, mid-run included; no pending strobe survives.
- States:
  - IDLE: loaded, not counting.
  - RUN: counting.
  - PAUSE: halted, value held.
  - DONE: ONE_SHOT=1 only, reached 0.
- Priority each cycle: load > stop > start > tick.
- load, from any state:
  - Next state IDLE.
  - If load_val < MOD: count <= load_val.
  - Otherwise count <= MOD-1 (clamp) and load_err=1 for exactly that next cycle.
  - Any start/stop/tick in the same cycle is ignored.
- stop in RUN -> PAUSE, count held. stop in any other state has no effect. start and stop together: stop wins.
- start:
  - IDLE or PAUSE -> RUN next cycle.
  - Exception: ONE_SHOT=1 with count==0 ignores start and stays put.
  - start in RUN or DONE is ignored.
- Tick: a tick is state RUN with en=1 and no load/stop that cycle.
  - count>0: count <= count-1.
  - count==0 and ONE_SHOT=0: count <= MOD-1; tc=1 in the cycle the new value appears.
  - count==1 and ONE_SHOT=1: count <= 0; tc=1 in the same cycle count reads 0; state -> DONE; running=0 from that cycle.
  - A ONE_SHOT run started at count 0 is impossible (start is blocked).
- en=0 in RUN holds count; state stays RUN and running stays 1.
- Latency: every output is registered. A strobe or tick at edge N is visible after edge N.
- tens/ones:
  - Always equal count/10 and count%10 in the same cycle.
  - Kept as BCD digit registers updated in lockstep with count, not decoded from the binary value.
  - Digit decrement: ones 0 -> 9 with borrow into tens.
  - Wrap loads the BCD digits of MOD-1; load loads the BCD of the clamped value.
- tc and load_err are never high for two consecutive cycles from a single event.
- DONE: holds count=0 until load (-> IDLE) or reset.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - a function converting a binary value < 100 to a {tens, ones} BCD pair, used by load/wrap and by the verification scoreboard;
  - the MOD range-check constant.
- One sub-module, bcd_digit_down: a 4-bit decade down-counter with dec_in, load, load_val and borrow_out. Instantiate it twice, chaining ones.borrow_out into tens.dec_in.

Test Plan:
- Reset mid-run: run from 57, pull rst_n low between edges -> count=0, tens=0, ones=0, running=0 immediately, before the next clk edge.
- Free-run wrap: load 3, start, en=1 -> count 3,2,1,0,99 (tens=9, ones=9); tc high only in the cycle showing 99.
- BCD borrow: load 40, start, one tick -> count=39, tens=3, ones=9.
- Clamp: load_val=120 -> count=99, load_err pulses one cycle, state IDLE, running=0.
- Pause/resume with en gaps: load 10, start, 3 ticks -> 7; stop+start same cycle -> PAUSE, count 7 held for 5 cycles; start; en toggling 1,0,1 -> 6,6,5.
- ONE_SHOT=1 build: load 2, start -> 1, then 0 with tc; DONE, running=0; further start ignored; load 5 -> IDLE, count=5.
